// File: rtl/mux_nto1_scan.sv
// N:1 registered multiplexer with a manual select mode and an auto-scan mode
// that sweeps every channel, dwelling DWELL cycles on each and pulsing wrap per sweep.
module mux_nto1_scan #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 4,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    d,
    input  logic [SW-1:0]     s,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      y,
    output logic [SW-1:0]     ch,
    output logic              y_vld,
    output logic              wrap
);

    localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SW:0]   N_L      = (SW+1)'(N);
    localparam logic [SW-1:0] IDX_LAST = SW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [SW-1:0]  r_idx,   w_idx_nxt;
    logic [CW-1:0]  r_cnt,   w_cnt_nxt;
    logic [W-1:0]   r_y,     w_y_nxt;
    logic [SW-1:0]  r_ch,    w_ch_nxt;
    logic           r_vld,   w_vld_nxt;
    logic           r_wrap,  w_wrap_nxt;

    // Channel selector; unmatched select values (>= N) yield zero.
    function automatic logic [W-1:0] chan_sel(input logic [N*W-1:0] dv,
                                              input logic [SW-1:0]  sel);
        logic [W-1:0] v;
        v = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            v = (sel == SW'(i)) ? dv[i*W +: W] : v;
        end
        return v;
    endfunction

    // Next-state and next-output logic; manual mode keeps the scan position
    // cleared so any entry into scan starts a fresh sweep at channel 0.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_y_nxt     = r_y;
        w_ch_nxt    = r_ch;
        w_vld_nxt   = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else if (!mode) begin
            w_state_nxt = ST_MANUAL;
            w_idx_nxt   = {SW{1'b0}};
            w_cnt_nxt   = {CW{1'b0}};
            w_ch_nxt    = s;
            if ({1'b0, s} < N_L) begin
                w_y_nxt   = chan_sel(d, s);
                w_vld_nxt = 1'b1;
            end else begin
                w_y_nxt   = {W{1'b0}};
                w_vld_nxt = 1'b0;
            end
        end else begin
            w_state_nxt = ST_SCAN;
            w_y_nxt     = chan_sel(d, r_idx);
            w_ch_nxt    = r_idx;
            w_vld_nxt   = 1'b1;
            if (r_cnt == CNT_LAST) begin
                w_cnt_nxt  = {CW{1'b0}};
                w_idx_nxt  = (r_idx == IDX_LAST) ? {SW{1'b0}} : r_idx + SW'(1);
                w_wrap_nxt = (r_idx == IDX_LAST);
            end else begin
                w_cnt_nxt  = r_cnt + CW'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= {SW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_y     <= {W{1'b0}};
            r_ch    <= {SW{1'b0}};
            r_vld   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
            r_ch    <= w_ch_nxt;
            r_vld   <= w_vld_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign y     = r_y;
    assign ch    = r_ch;
    assign y_vld = r_vld;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Scoreboard bench for mux_nto1_scan: a 4-channel DWELL=2 instance and a
// 3-channel DWELL=1 instance share stimulus; expectations are queued per instance.
module tb_mux_nto1_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_a;
    logic [23:0] d_b;
    logic [1:0]  s;
    logic        mode, en;
    logic [7:0]  y_a, y_b;
    logic [1:0]  ch_a, ch_b;
    logic        vld_a, vld_b, wrap_a, wrap_b;

    int total = 0;
    int bad   = 0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    always #5 clk = ~clk;

    mux_nto1_scan #(.N(4), .W(8), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .d(d_a), .s(s), .mode(mode), .en(en),
        .y(y_a), .ch(ch_a), .y_vld(vld_a), .wrap(wrap_a));

    mux_nto1_scan #(.N(3), .W(8), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .d(d_b), .s(s), .mode(mode), .en(en),
        .y(y_b), .ch(ch_b), .y_vld(vld_b), .wrap(wrap_b));

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got y=%h ch=%0d vld=%b wrap=%b, want y=%h ch=%0d vld=%b wrap=%b",
                     name, act[11:4], act[3:2], act[1], act[0], exp[11:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [11:0] mk(input logic [7:0] yy, input logic [1:0] cc,
                                       input logic vv, input logic ww);
        return {yy, cc, vv, ww};
    endfunction

    task automatic push_a(input logic [7:0] yy, input logic [1:0] cc, input logic vv, input logic ww);
        qa.push_back(mk(yy, cc, vv, ww));
    endtask

    task automatic push_b(input logic [7:0] yy, input logic [1:0] cc, input logic vv, input logic ww);
        qb.push_back(mk(yy, cc, vv, ww));
    endtask

    // Inputs change just after a falling edge, so each pushed expectation
    // belongs to the very next rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare whatever each instance presents against its queue.
    always @(negedge clk) begin
        if (qa.size() > 0) check("dut_a", {y_a, ch_a, vld_a, wrap_a}, qa.pop_front());
        if (qb.size() > 0) check("dut_b", {y_b, ch_b, vld_b, wrap_b}, qb.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] c;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; s = 2'd0;
        d_a = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        d_b = {8'hCC, 8'hBB, 8'hAA};
        tick();
        check("reset_state", {y_a, ch_a, vld_a, wrap_a}, 12'h000);
        rst_n = 1'b1;
        push_a(8'h00, 2'd0, 1'b0, 1'b0); tick();
        push_a(8'h00, 2'd0, 1'b0, 1'b0); tick();

        // Manual select of each channel.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            push_a(8'hAA + 8'(8'h11 * i), 2'(i), 1'b1, 1'b0);
            tick();
        end

        // Scan from reset: two cycles per channel, wrap on the second DD.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            c = 2'((k / 2) % 4);
            push_a(8'hAA + 8'(8'h11 * c), c, 1'b1, (k % 8) == 7);
            tick();
        end

        // Pause mid-dwell on BB and resume with the remaining dwell.
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hBB, 2'd1, 1'b1, 1'b0); tick();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_a(8'hBB, 2'd1, 1'b0, 1'b0); tick();
        end
        en = 1'b1;
        push_a(8'hBB, 2'd1, 1'b1, 1'b0); tick();
        push_a(8'hCC, 2'd2, 1'b1, 1'b0); tick();
        push_a(8'hCC, 2'd2, 1'b1, 1'b0); tick();
        push_a(8'hDD, 2'd3, 1'b1, 1'b0); tick();
        push_a(8'hDD, 2'd3, 1'b1, 1'b1); tick();

        // Scan to channel 2, drop to manual, then restart the sweep.
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hBB, 2'd1, 1'b1, 1'b0); tick();
        push_a(8'hBB, 2'd1, 1'b1, 1'b0); tick();
        push_a(8'hCC, 2'd2, 1'b1, 1'b0); tick();
        mode = 1'b0; s = 2'd1;
        push_a(8'hBB, 2'd1, 1'b1, 1'b0); tick();
        mode = 1'b1;
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hBB, 2'd1, 1'b1, 1'b0); tick();

        // Three-channel instance: out-of-range select, then DWELL=1 scan.
        mode = 1'b0; s = 2'd3;
        push_b(8'h00, 2'd3, 1'b0, 1'b0); tick();
        s = 2'd2;
        push_b(8'hCC, 2'd2, 1'b1, 1'b0); tick();
        mode = 1'b1;
        for (int k = 0; k < 7; k++) begin
            c = 2'(k % 3);
            push_b(8'hAA + 8'(8'h11 * c), c, 1'b1, c == 2'd2);
            tick();
        end

        // Asynchronous reset between edges, then a fresh sweep.
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("async_reset", {y_a, ch_a, vld_a, wrap_a}, 12'h000);
        tick();
        rst_n = 1'b1;
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hAA, 2'd0, 1'b1, 1'b0); tick();
        push_a(8'hBB, 2'd1, 1'b1, 1'b0); tick();

        // Data change while dwelling is followed on the next edge.
        d_a[15:8] = 8'h5A;
        push_a(8'h5A, 2'd1, 1'b1, 1'b0); tick();

        tick();
        if (qa.size() != 0 || qb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
Parametrised N:1 multiplexer that generalises the 2:1 mux to N channels of W bits each. The output is registered and a valid flag is provided.
- Manual mode: the output tracks an external select, like the 2:1 mux.
- Scan mode: an internal counter steps through all channels in turn, holding each one for DWELL cycles. A wrap pulse marks the end of each full sweep.
- Used on the Mimas V2 board to time-multiplex switch and sensor inputs onto one display or UART path.

Parameters:
N, 4, number of input channels (2..16; need not be a power of 2).
W, 8, data width per channel (>=1).
DWELL, 4, clock cycles each channel is held in scan mode (>=1).
SW, derived localparam = max(1, clog2(N)), width of select and channel index.

Ports:
clk  in  1  system clock; all flops are rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
d  in  N*W  packed channel inputs; channel i occupies d[i*W +: W].
s  in  SW  manual channel select; used only when mode=0.
mode  in  1  0 = manual select, 1 = auto-scan.
en  in  1  enable; when low, all state is frozen.
y  out  W  registered mux output.
ch  out  SW  index of the channel currently on y.
y_vld  out  1  high when y holds a sample captured in the previous cycle.
wrap  out  1  one-cycle pulse; last sample of channel N-1 in scan mode.

Behaviour:
- Reset (rst_n=0, asynchronous): y=0, ch=0, y_vld=0, wrap=0, scan index idx=0, dwell count cnt=0, state=IDLE. After rst_n deasserts, outputs stay at these values until the first rising edge with en=1.
- Latency: exactly one clock from d/s/mode/en sampled at a rising edge to y/ch/y_vld. There is no combinational path from any input to any output.
- State machine, evaluated at each rising edge (priority: en, then mode):
  - IDLE: entered whenever en=0. y and ch hold, y_vld<=0, wrap<=0, idx and cnt frozen.
  - MANUAL: entered when en=1, mode=0.
  - SCAN: entered when en=1, mode=1.
- MANUAL behaviour:
  - s<N: y<=d[s], ch<=s, y_vld<=1, wrap<=0.
  - s>=N (out-of-range, only possible when N is not a power of 2): y<=0, ch<=s, y_vld<=0.
- SCAN behaviour:
  - Each cycle: y<=d[idx], ch<=idx, y_vld<=1.
  - If cnt==DWELL-1: cnt<=0 and idx advances; idx wraps to 0 after N-1, never reaching N..2^SW-1.
  - Otherwise: cnt<=cnt+1.
  - wrap<=1 only in the capture cycle where idx==N-1 and cnt==DWELL-1; otherwise wrap<=0.
  - DWELL=1: channel advances every cycle and wrap pulses every N cycles.
- Mode transitions:
  - MANUAL->SCAN: idx and cnt clear to 0 on the transition edge, so the first scan sample is channel 0, held a full DWELL cycles.
  - SCAN->MANUAL: the next sample uses s immediately; idx and cnt clear to 0.
- en deasserted mid-scan: idx and cnt freeze. When en returns with mode=1, the scan resumes at the same channel with the remaining dwell count. Toggling en does not restart the sweep.
- Asynchronous reset mid-scan: all state returns to reset values immediately, without waiting for a clock edge.
- d changes while dwelling on a channel: y follows the new value on the next edge. The sample is not latched once per dwell.

Test Plan:
1. Parameters N=4, W=8, DWELL=2; d={DD,CC,BB,AA}; manual mode; s=0,1,2,3 on successive cycles -> y=AA,BB,CC,DD, ch=0..3, y_vld=1, each one cycle after s.
2. Same d, mode=1 from reset -> y=AA,AA,BB,BB,CC,CC,DD,DD, then AA again. wrap=1 only alongside the second DD, repeating every 8 cycles.
3. Scan running with y=BB and cnt=0; drop en for 3 cycles, then restore -> y holds BB with y_vld=0 during the pause. After restore: one more BB, then CC,CC, etc. No wrap during the pause.
4. Scan at channel 2; switch mode to 0 with s=1 -> next y=BB, ch=1. Switch back to mode=1 -> y=AA,AA,BB,...
5. Rebuild with N=3, W=8, DWELL=1; manual s=3 -> y=00, y_vld=0. Scan mode -> ch=0,1,2,0 with wrap every third cycle.
6. Pull rst_n low between clock edges during scan -> y=0, ch=0, y_vld=0, wrap=0 immediately. After release with en=1, mode=1 -> the sweep restarts at AA.
